// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Ready and valid are decoded from registered state only; flush inserts a bubble.
module pipe_stage_skid #(
   parameter int DW = 69,
   parameter int CW = 4
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          flush,
   input  logic          e_valid,
   output logic          e_ready,
   input  logic [CW-1:0] e_ctrl,
   input  logic [DW-1:0] e_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [CW-1:0] m_ctrl,
   output logic [DW-1:0] m_data,
   output logic [1:0]    occ
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t        state_r,     state_s;
   logic [CW-1:0] main_ctrl_r, main_ctrl_s;
   logic [DW-1:0] main_data_r, main_data_s;
   logic [CW-1:0] skid_ctrl_r, skid_ctrl_s;
   logic [DW-1:0] skid_data_r, skid_data_s;
   logic          acc_s;
   logic          take_s;

   // Output decode from registered state only.
   always_comb begin
      m_valid = 1'b0;
      e_ready = 1'b1;
      occ     = 2'd0;
      case (state_r)
         ST_EMPTY: begin
            m_valid = 1'b0;
            e_ready = 1'b1;
            occ     = 2'd0;
         end
         ST_ONE: begin
            m_valid = 1'b1;
            e_ready = 1'b1;
            occ     = 2'd1;
         end
         ST_FULL: begin
            m_valid = 1'b1;
            e_ready = 1'b0;
            occ     = 2'd2;
         end
         default: begin
            m_valid = 1'b0;
            e_ready = 1'b1;
            occ     = 2'd0;
         end
      endcase
   end

   assign m_ctrl = main_ctrl_r;
   assign m_data = main_data_r;
   assign acc_s  = e_valid & e_ready;
   assign take_s = m_valid & m_ready;

   // Next-state and register-update logic; consumed entries get their ctrl zeroed.
   always_comb begin
      state_s     = state_r;
      main_ctrl_s = main_ctrl_r;
      main_data_s = main_data_r;
      skid_ctrl_s = skid_ctrl_r;
      skid_data_s = skid_data_r;
      if (flush) begin
         state_s     = ST_EMPTY;
         main_ctrl_s = {CW{1'b0}};
         skid_ctrl_s = {CW{1'b0}};
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (acc_s) begin
                  main_ctrl_s = e_ctrl;
                  main_data_s = e_data;
                  state_s     = ST_ONE;
               end else begin
                  state_s     = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (acc_s && take_s) begin
                  main_ctrl_s = e_ctrl;
                  main_data_s = e_data;
                  state_s     = ST_ONE;
               end else if (acc_s) begin
                  skid_ctrl_s = e_ctrl;
                  skid_data_s = e_data;
                  state_s     = ST_FULL;
               end else if (take_s) begin
                  main_ctrl_s = {CW{1'b0}};
                  state_s     = ST_EMPTY;
               end else begin
                  state_s     = ST_ONE;
               end
            end
            ST_FULL: begin
               if (take_s) begin
                  main_ctrl_s = skid_ctrl_r;
                  main_data_s = skid_data_r;
                  skid_ctrl_s = {CW{1'b0}};
                  state_s     = ST_ONE;
               end else begin
                  state_s     = ST_FULL;
               end
            end
            default: begin
               state_s     = ST_EMPTY;
               main_ctrl_s = {CW{1'b0}};
               skid_ctrl_s = {CW{1'b0}};
            end
         endcase
      end
   end

   // State and storage registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_r     <= ST_EMPTY;
         main_ctrl_r <= {CW{1'b0}};
         main_data_r <= {DW{1'b0}};
         skid_ctrl_r <= {CW{1'b0}};
         skid_data_r <= {DW{1'b0}};
      end else begin
         state_r     <= state_s;
         main_ctrl_r <= main_ctrl_s;
         main_data_r <= main_data_s;
         skid_ctrl_r <= skid_ctrl_s;
         skid_data_r <= skid_data_s;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, all checked
// against a 2-deep FIFO queue model with registered-ready acceptance.
module tb_pipe_stage_skid;

   logic        clock;
   logic        resetn;
   logic        flush;
   logic        e_valid;
   logic        e_ready;
   logic [3:0]  e_ctrl;
   logic [68:0] e_data;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_ctrl;
   logic [68:0] m_data;
   logic [1:0]  occ;

   typedef struct packed {
      logic [3:0]  c;
      logic [68:0] d;
   } ent_t;

   ent_t q[$];
   bit   data_zero_known;
   int   total;
   int   bad;

   pipe_stage_skid #(.DW(69), .CW(4)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .flush   (flush),
      .e_valid (e_valid),
      .e_ready (e_ready),
      .e_ctrl  (e_ctrl),
      .e_data  (e_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_ctrl  (m_ctrl),
      .m_data  (m_data),
      .occ     (occ)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int n;
      n = q.size();
      chk("m_valid", 128'(m_valid), (n > 0) ? 128'd1 : 128'd0);
      chk("e_ready", 128'(e_ready), (n < 2) ? 128'd1 : 128'd0);
      chk("occ",     128'(occ),     128'(n));
      chk("m_ctrl",  128'(m_ctrl),  (n > 0) ? 128'(q[0].c) : 128'd0);
      if (n > 0) chk("m_data", 128'(m_data), 128'(q[0].d));
      else if (data_zero_known) chk("m_data_reset", 128'(m_data), 128'd0);
   endtask

   // One clock: drive at negedge, check, then apply the FIFO model at posedge.
   task automatic step(input logic rn, input logic fl, input logic ev,
                       input logic [3:0] ec, input logic [68:0] ed,
                       input logic mr, input bit do_chk);
      bit room;
      bit out_taken;
      @(negedge clock);
      resetn  = rn;
      flush   = fl;
      e_valid = ev;
      e_ctrl  = ec;
      e_data  = ed;
      m_ready = mr;
      if (do_chk) check_outputs();
      @(posedge clock);
      if (!rn) begin
         q.delete();
         data_zero_known = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         room      = (q.size() < 2);
         out_taken = (q.size() > 0) && mr;
         if (out_taken) void'(q.pop_front());
         if (ev && room) begin
            q.push_back('{c: ec, d: ed});
            data_zero_known = 1'b0;
         end
      end
   endtask

   initial begin
      logic [95:0] rnd;
      total = 0;
      bad   = 0;
      data_zero_known = 1'b0;
      resetn = 1'b0; flush = 1'b0; e_valid = 1'b0; e_ctrl = 4'h0;
      e_data = 69'h0; m_ready = 1'b0;

      // Reset with traffic offered; first cycle's outputs are still unknown.
      step(1'b0, 1'b0, 1'b1, 4'hF, 69'h1F, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'hF, 69'h1F, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h5, 69'h1_2345_6789_ABCD_EF01, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0, 1'b1);

      // Streaming at full throughput.
      for (int i = 1; i <= 8; i++)
         step(1'b1, 1'b0, 1'b1, 4'b1001, 69'(i), 1'b1, 1'b1);
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);

      // Back-pressure into the skid register, then drain in order.
      step(1'b1, 1'b0, 1'b1, 4'h3, 69'd1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h3, 69'd2, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h3, 69'd3, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h3, 69'd3, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h3, 69'd3, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);

      // Flush while full, with an entry offered on the flush cycle.
      step(1'b1, 1'b0, 1'b1, 4'hA, 69'd7, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'hB, 69'd8, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'hC, 69'd9, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);

      // Bubble ctrl after a single entry is taken.
      step(1'b1, 1'b0, 1'b1, 4'b0111, 69'h55, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0, 1'b1);

      // Reset takes priority over flush while full.
      step(1'b1, 1'b0, 1'b1, 4'h6, 69'h66, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h7, 69'h77, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 4'h8, 69'h88, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h9, 69'h99, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0, 1'b1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         rnd = {$urandom(), $urandom(), $urandom()};
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd[68:0],
              ($urandom_range(0, 3) != 0), 1'b1);
      end
      step(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
